// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit RISC-V M-extension multiply/divide unit.
// Multiply is a 32-step shift-add on operand magnitudes with a final sign fix.
// Divide is a 32-step restoring shift-subtract on magnitudes.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;
  logic [2:0]  op_r;
  logic        neg_r;
  logic [5:0]  cnt_r;
  logic [63:0] acc_r;     // product accumulator, or {remainder, dividend/quotient}
  logic [63:0] opb_r;     // shifting multiplicand, or divisor in the low half
  logic [31:0] mplier_r;  // multiplier magnitude, consumed LSB first

  logic        last_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic        neg_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic [63:0] mul_sum_s;
  logic [32:0] trial_s;
  logic [63:0] acc_next_s;
  logic [63:0] prod_s;
  logic [31:0] div_sel_s;
  logic [31:0] div_res_s;
  logic [31:0] final_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign last_s = (cnt_r == 6'd31);

  // Operand signedness per operation, magnitudes, and the final sign flag.
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    neg_s    = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a_s = a[31];
        sign_b_s = b[31];
      end
      3'b010: begin
        sign_a_s = a[31];
        sign_b_s = 1'b0;
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    // Remainder follows the dividend sign; everything else uses the sign product.
    if (funct3 == 3'b110) begin
      neg_s = sign_a_s;
    end else begin
      neg_s = sign_a_s ^ sign_b_s;
    end
    mag_a_s = sign_a_s ? (32'h0000_0000 - a) : a;
    mag_b_s = sign_b_s ? (32'h0000_0000 - b) : b;
  end

  // Division special cases: divide by zero and signed overflow.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'h0000_0000;
    if (funct3[2] && (b == 32'h0000_0000)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? a : 32'hFFFF_FFFF;
    end else if (funct3[2] && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'h0000_0000;
    end
  end

  // One iteration step of shift-add or restoring subtract, and the signed final result.
  always_comb begin
    mul_sum_s = acc_r + (mplier_r[0] ? opb_r : 64'h0000_0000_0000_0000);
    trial_s   = {acc_r[63:32], acc_r[31]} - {1'b0, opb_r[31:0]};
    if (state_r == DIV) begin
      if (trial_s[32]) begin
        acc_next_s = {acc_r[62:0], 1'b0};
      end else begin
        acc_next_s = {trial_s[31:0], acc_r[30:0], 1'b1};
      end
    end else begin
      acc_next_s = mul_sum_s;
    end
    prod_s    = neg_r ? (64'h0000_0000_0000_0000 - acc_next_s) : acc_next_s;
    div_sel_s = op_r[1] ? acc_next_s[63:32] : acc_next_s[31:0];
    div_res_s = neg_r ? (32'h0000_0000 - div_sel_s) : div_sel_s;
    if (op_r[2]) begin
      final_s = div_res_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_s = prod_s[31:0];
    end else begin
      final_s = prod_s[63:32];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (special_s) begin
            state_s = DONE;
          end else if (funct3[2]) begin
            state_s = DIV;
          end else begin
            state_s = MUL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with busy/done registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: operand capture on accept, one bit per cycle while iterating.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= 32'h0000_0000;
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      cnt_r    <= 6'd0;
      acc_r    <= 64'h0000_0000_0000_0000;
      opb_r    <= 64'h0000_0000_0000_0000;
      mplier_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r  <= funct3;
            neg_r <= neg_s;
            cnt_r <= 6'd0;
            if (special_s) begin
              result_r <= special_res_s;
            end else if (funct3[2]) begin
              acc_r    <= {32'h0000_0000, mag_a_s};
              opb_r    <= {32'h0000_0000, mag_b_s};
              mplier_r <= 32'h0000_0000;
            end else begin
              acc_r    <= 64'h0000_0000_0000_0000;
              opb_r    <= {32'h0000_0000, mag_a_s};
              mplier_r <= mag_b_s;
            end
          end
        end
        MUL, DIV: begin
          acc_r    <= acc_next_s;
          mplier_r <= {1'b0, mplier_r[31:1]};
          if (state_r == MUL) begin
            opb_r <= {opb_r[62:0], 1'b0};
          end
          if (last_s) begin
            cnt_r    <= 6'd0;
            result_r <= final_s;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result and
// latency on each issued operation; a monitor checks every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   nchecks = 0;
  int   nfail = 0;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        nchecks++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      nchecks++;
      nfail++;
      $display("FAIL wait_idle: got busy=%b expected 0 within 200 cycles", busy);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    wait_idle();
    start  = 1'b1;
    funct3 = f;
    a      = av;
    b      = bv;
    e.res  = exp;
    e.lat  = lat;
    e.acc  = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      nchecks++;
      nfail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] exp, input int lat);
    issue(f, av, bv, exp, lat);
    drain();
  endtask

  initial begin
    exp_t e;
    int acc0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Multiply
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run(3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run(3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    run(3'b000, 32'd0, 32'h0001_2345, 32'h0000_0000, 33);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    // Divide
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run(3'b101, 32'd100, 32'd7, 32'd14, 33);
    run(3'b111, 32'd100, 32'd7, 32'd2, 33);
    run(3'b100, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);
    // Special cases
    run(3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
    run(3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

    // Inputs toggled while busy must not disturb the operation
    issue(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
      if (k >= 4 && k <= 9) begin
        start  = 1'b1;
        funct3 = 3'b100;
        a      = $urandom;
        b      = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    drain();
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);

    // Reset in cycle 15 of a DIV aborts it with no done
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

    // Reset wins over a same-cycle start
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    funct3 = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("reset_prio_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Start held high: accepts every 34 cycles
    wait_idle();
    start  = 1'b1;
    funct3 = 3'b000;
    a      = 32'd3;
    b      = 32'd5;
    acc0   = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.res = 32'd15;
      e.lat = 33;
      e.acc = acc0 + 34 * i;
      sb_q.push_back(e);
    end
    repeat (101) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL have no other clock or asynchronous input.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port start  input  1  request strobe; only sampled while busy=0.
REQ-005 Port funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port a  input  32  operand rs1, as the multiplicand or the dividend.
REQ-007 Port b  input  32  operand rs2, as the multiplier or the divisor.
REQ-008 Port busy  output  1  high while an operation is in progress, including the done cycle.
REQ-009 Port done  output  1  single-cycle pulse; result is valid in this cycle.
REQ-010 Port result  output  32  registered result; holds its value until the next accepted start.

Function
REQ-011 An operation SHALL be accepted when start=1 and busy=0 at a rising clk edge; in this document that is cycle 0, and funct3, a and b SHALL be captured at that edge.
REQ-012 While busy=1, start, funct3, a and b SHALL be ignored, and a change to them SHALL have no effect on the operation in progress.
REQ-013 The block SHALL have four states: IDLE, MUL, DIV and DONE.
REQ-014 From IDLE, an accepted start with funct3[2]=0 SHALL go to MUL, and with funct3[2]=1 SHALL go to DIV; a division special case (see REQ-019 and REQ-020) SHALL go directly to DONE.
REQ-015 MUL and DIV SHALL each run exactly 32 iteration cycles (cycles 1-32), processing one bit per cycle, and then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, busy=1 and result valid, and SHALL then return to IDLE; for the normal path DONE is cycle 33, and for a special case it is cycle 1.
REQ-017 Multiply SHALL use an iterative shift-add on operand magnitudes with a 64-bit product and a final sign correction.
- MUL: low 32 bits of the product.
- MULH: high 32 bits, with signed × signed operands.
- MULHSU: high 32 bits, with signed a × unsigned b.
- MULHU: high 32 bits, with unsigned × unsigned operands.
REQ-018 Divide SHALL use a restoring shift-subtract on operand magnitudes.
- Signed quotient truncates toward zero.
- Signed remainder takes the sign of the dividend.
- Unsigned operations use the raw operand values.
REQ-019 When b=0, the result SHALL be: DIV and DIVU 0xFFFFFFFF; REM and REMU equal to a.
REQ-020 For signed overflow (a=0x80000000, b=0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0x00000000.
REQ-021 Special cases SHALL take priority over the iterative path and SHALL NOT enter the DIV state.
REQ-022 A multiply by zero SHALL still take the full 33-cycle latency; there SHALL be no early termination.
REQ-023 A start held high through DONE SHALL NOT be accepted until the cycle after DONE, when busy=0; back-to-back accepted starts are therefore at least 34 cycles apart on the normal path.
REQ-024 done SHALL be high in exactly one cycle per accepted operation.
REQ-025 The iteration counter SHALL be 6 bits wide, SHALL count 0-31, and SHALL NOT wrap into a new operation.

Reset
REQ-026 reset=1 at a rising edge SHALL force the state to IDLE and set busy=0, done=0, result=0x00000000, the counter to 0 and all datapath registers to 0.
REQ-027 reset SHALL take priority over start in the same cycle, and that start SHALL be dropped.
REQ-028 A reset asserted in the middle of an operation SHALL abort it with no done pulse; a start accepted after reset deasserts SHALL behave as a fresh operation.

Verification
REQ-029 Scenario: MUL with a=7, b=0xFFFFFFFD -> done in cycle 33, result 0xFFFFFFEB; MULH with the same operands -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000006.
REQ-030 Scenario: DIV with a=0xFFFFFFF9 (-7), b=2 -> done in cycle 33, result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with a=100, b=7 -> 14; REMU with a=100, b=7 -> 2.
REQ-031 Scenario: DIVU with a=0x1234, b=0 -> done in cycle 1, result 0xFFFFFFFF; REMU with the same operands -> 0x00001234; DIV with a=0x80000000, b=0xFFFFFFFF -> done in cycle 1, result 0x80000000.
REQ-032 Scenario: start a MUL, then pulse start again and change a and b in cycles 5-10 -> the result is unchanged, there is exactly one done pulse, and busy stays 1 through cycle 33.
REQ-033 Scenario: assert reset in cycle 15 of a DIV -> the next cycle shows busy=0, done=0, result=0, with no done pulse; a new MULHSU with a=0xFFFFFFFF, b=2 then returns 0xFFFFFFFF in its cycle 33.
REQ-034 Scenario: start held high continuously with a=3, b=5, MUL -> accepts occur in cycles 0, 34 and 68, and done pulses occur in cycles 33, 67 and 101, each with result 15.
